tis_output_sink: RTL and testbench

Consumer for one bottom-edge output port of `corecomplex`: completes the TIS word handshake with the bottom-row core, latches each 11-bit signed value, and scores the stream against an expected sequence. Its `count`/`correct` outputs drive the bench's `count`/`correct` signals. It also serves as the pattern for an FPGA output node.

---
 rtl/tis_pkg.sv | 21 ++
 rtl/tis_port_rx.sv | 65 ++++++
 rtl/tis_output_sink.sv | 119 +++++++++++
 tb/tb_tis_output_sink.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tis_pkg
// Description : Shared TIS word type, value range and port-reader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package tis_pkg;

    typedef logic signed [10:0] word_t;

    localparam word_t TIS_MIN = -11'sd999;
    localparam word_t TIS_MAX = 11'sd999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DROP = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/tis_port_rx.sv
`default_nettype none
// ============================================================================
// Module      : tis_port_rx
// Description : TIS reader handshake FSM with capture register; rst is
//               asynchronous and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module tis_port_rx
    import tis_pkg::*;
#(
    parameter int WIDTH = 11
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             rready,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic             read,
    output logic [WIDTH-1:0] value,
    output logic             take
);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic             w_capture;
    logic             r_read;
    logic [WIDTH-1:0] r_value;

    // en gates only new acceptances; an ACK/DROP already under way runs out.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rready && en) begin
                    w_state_nxt = ACK;
                    w_capture   = 1'b1;
                end
            end
            ACK:     w_state_nxt = DROP;
            DROP:    if (!rready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_value <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_read  <= w_capture;
            if (w_capture) begin
                r_value <= in;
            end
        end
    end

    assign read  = r_read;
    assign take  = r_read;
    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/tis_output_sink.sv
`default_nettype none
// ============================================================================
// Module      : tis_output_sink
// Description : Bottom-edge TIS output consumer; accepts words and scores them
//               against an expected sequence. rst is asynchronous, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module tis_output_sink
    import tis_pkg::*;
#(
    parameter int WIDTH   = 11,
    parameter int EXP_LEN = 39,
    parameter int CNT_W   = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             rready,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic [WIDTH-1:0] expected [0:EXP_LEN-1],
    output logic             read,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] correct,
    output logic             err,
    output logic [CNT_W-1:0] err_idx,
    output logic             done
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             w_take;
    logic [WIDTH-1:0] w_value;
    logic [WIDTH-1:0] w_ref;
    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_correct;
    logic [CNT_W-1:0] r_err_idx;
    logic             r_err;
    logic             r_done;

    // Assert immediately, release only after two clean clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    tis_port_rx #(
        .WIDTH (WIDTH)
    ) u_rx (
        .clk    (clk),
        .rst    (w_rst_n),
        .rready (rready),
        .in     (in),
        .en     (en),
        .read   (read),
        .value  (w_value),
        .take   (w_take)
    );

    // Reference lookup; indices past the table read as zero and are never scored.
    always_comb begin
        w_ref = '0;
        for (int i = 0; i < EXP_LEN; i++) begin
            if (int'(r_count) == i) begin
                w_ref = expected[i];
            end
        end
    end

    assign w_count_inc = (r_count == C_CNT_MAX) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_count   <= '0;
            r_correct <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_done    <= 1'b0;
        end else if (w_take) begin
            r_count <= w_count_inc;
            if (r_done) begin
                // Overflow word: unscored, but flagged once.
                if (!r_err) begin
                    r_err     <= 1'b1;
                    r_err_idx <= r_count;
                end
            end else if (w_value == w_ref) begin
                if (r_correct != C_CNT_MAX) begin
                    r_correct <= r_correct + CNT_W'(1);
                end
            end else if (!r_err) begin
                r_err     <= 1'b1;
                r_err_idx <= r_count;
            end
            if (int'(w_count_inc) == EXP_LEN) begin
                r_done <= 1'b1;
            end
        end
    end

    assign value   = w_value;
    assign valid   = w_take;
    assign count   = r_count;
    assign correct = r_correct;
    assign err     = r_err;
    assign err_idx = r_err_idx;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tis_output_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_tis_output_sink
// Description : Scoreboard bench for tis_output_sink (two parameterisations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tis_output_sink;

    typedef struct {
        int val;
        int cnt;
        int cor;
        int err;
        int eidx;
        int done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic [10:0] din = '0;
    logic        rready_a = 1'b0;
    logic        rready_b = 1'b0;

    logic [10:0] exp_a [0:3];
    logic [10:0] exp_b [0:6];

    logic        read_a, valid_a, err_a, done_a;
    logic [10:0] value_a;
    logic [7:0]  count_a, correct_a, err_idx_a;
    logic        read_b, valid_b, err_b, done_b;
    logic [10:0] value_b;
    logic [2:0]  count_b, correct_b, err_idx_b;

    int   checks = 0;
    int   errors = 0;
    int   reads_a = 0;
    int   reads_b = 0;
    int   r0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t pe_a, pe_b;
    bit   pend_a = 1'b0;
    bit   pend_b = 1'b0;

    always #5 clk = ~clk;

    tis_output_sink #(.WIDTH(11), .EXP_LEN(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .rready(rready_a), .in(din), .en(en),
        .expected(exp_a), .read(read_a), .value(value_a), .valid(valid_a),
        .count(count_a), .correct(correct_a), .err(err_a),
        .err_idx(err_idx_a), .done(done_a)
    );

    tis_output_sink #(.WIDTH(11), .EXP_LEN(7), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .rready(rready_b), .in(din), .en(en),
        .expected(exp_b), .read(read_b), .value(value_b), .valid(valid_b),
        .count(count_b), .correct(correct_b), .err(err_b),
        .err_idx(err_idx_b), .done(done_b)
    );

    task automatic cmp(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic chk_cnt(input string p, input exp_t e, input int c, input int r,
                           input int er, input int ei, input int dn);
        cmp({p, "_count"},   c,  e.cnt);
        cmp({p, "_correct"}, r,  e.cor);
        cmp({p, "_err"},     er, e.err);
        cmp({p, "_err_idx"}, ei, e.eidx);
        cmp({p, "_done"},    dn, e.done);
    endtask

    task automatic push_a(input int v, input int c, input int r, input int e,
                          input int i, input int d);
        exp_t t;
        t = '{v, c, r, e, i, d};
        q_a.push_back(t);
    endtask

    task automatic push_b(input int v, input int c, input int r, input int e,
                          input int i, input int d);
        exp_t t;
        t = '{v, c, r, e, i, d};
        q_b.push_back(t);
    endtask

    // Monitors: check the word on valid, then the counters one cycle later.
    always @(negedge clk) begin
        if (pend_a) begin
            chk_cnt("a", pe_a, int'(count_a), int'(correct_a), int'(err_a),
                    int'(err_idx_a), int'(done_a));
            pend_a = 1'b0;
        end
        if (read_a) reads_a++;
        if (valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got value %0d, required no output",
                         $signed(value_a));
            end else begin
                pe_a = q_a.pop_front();
                cmp("a_value", $signed(value_a), pe_a.val);
                cmp("a_read_with_valid", read_a, 1);
                pend_a = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (pend_b) begin
            chk_cnt("b", pe_b, int'(count_b), int'(correct_b), int'(err_b),
                    int'(err_idx_b), int'(done_b));
            pend_b = 1'b0;
        end
        if (read_b) reads_b++;
        if (valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got value %0d, required no output",
                         $signed(value_b));
            end else begin
                pe_b = q_b.pop_front();
                cmp("b_value", $signed(value_b), pe_b.val);
                pend_b = 1'b1;
            end
        end
    end

    task automatic wait_read(input int d, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d == 0 ? read_a : read_b) && n < 40);
        if (!(d == 0 ? read_a : read_b)) begin
            checks++;
            errors++;
            $display("FAIL %s: got no read within 40 cycles, required read", nm);
        end
    endtask

    // Writer: present the word, drop rready the edge after read (plus hold).
    task automatic send(input int d, input int v, input int hold);
        @(posedge clk);
        #1;
        din = 11'(v);
        if (d == 0) rready_a = 1'b1; else rready_b = 1'b1;
        wait_read(d, "send_handshake");
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1;
        if (d == 0) rready_a = 1'b0; else rready_b = 1'b0;
    endtask

    task automatic chk_zero(input string p);
        cmp({p, "_read"},    read_a,    0);
        cmp({p, "_valid"},   valid_a,   0);
        cmp({p, "_value"},   value_a,   0);
        cmp({p, "_count"},   count_a,   0);
        cmp({p, "_correct"}, correct_a, 0);
        cmp({p, "_err"},     err_a,     0);
        cmp({p, "_err_idx"}, err_idx_a, 0);
        cmp({p, "_done"},    done_a,    0);
        cmp({p, "_b_count"}, count_b,   0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_a[0] = 11'd5;
        exp_a[1] = 11'h7FD;   // -3
        exp_a[2] = 11'd999;
        exp_a[3] = 11'd0;
        for (int i = 0; i < 7; i++) exp_b[i] = 11'(i + 1);

        do_reset();

        // Nominal run, then one overflow word.
        push_a(5,   1, 1, 0, 0, 0); send(0, 5,   0);
        push_a(-3,  2, 2, 0, 0, 0); send(0, -3,  0);
        push_a(999, 3, 3, 0, 0, 0); send(0, 999, 0);
        push_a(0,   4, 4, 0, 0, 1); send(0, 0,   0);
        push_a(7,   5, 4, 1, 4, 1); send(0, 7,   0);

        // Reset during ACK with rready still held.
        @(posedge clk);
        #1;
        din = 11'd11;
        rready_a = 1'b1;
        @(posedge clk);
        #2;
        cmp("rst_pre_read", read_a, 1);
        rst = 1'b0;
        #1;
        chk_zero("rst_mid_ack");
        push_a(11, 1, 0, 1, 0, 0);
        r0 = reads_a;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        cmp("rst_release_no_early_read", reads_a - r0, 0);
        wait_read(0, "rst_reaccept");
        @(posedge clk);
        #1;
        rready_a = 1'b0;

        // Mismatch run.
        do_reset();
        push_a(5,   1, 1, 0, 0, 0); send(0, 5,   0);
        push_a(-2,  2, 1, 1, 1, 0); send(0, -2,  0);
        push_a(999, 3, 2, 1, 1, 0); send(0, 999, 0);
        push_a(0,   4, 3, 1, 1, 1); send(0, 0,   0);

        // Held rready: one acknowledge only.
        do_reset();
        r0 = reads_a;
        push_a(7, 1, 0, 1, 0, 0);
        send(0, 7, 10);
        repeat (2) @(posedge clk);
        #1;
        cmp("held_single_read", reads_a - r0, 1);

        // Backpressure while idle.
        @(posedge clk);
        #1;
        en = 1'b0;
        din = 11'h7FD;
        rready_a = 1'b1;
        r0 = reads_a;
        repeat (6) @(posedge clk);
        #1;
        cmp("bp_no_read", reads_a - r0, 0);
        push_a(-3, 2, 1, 1, 0, 0);
        en = 1'b1;
        @(negedge clk);
        cmp("bp_read_early", read_a, 0);
        @(negedge clk);
        cmp("bp_read_arrival", read_a, 1);
        @(posedge clk);
        #1;
        rready_a = 1'b0;

        // en drops mid-ACK: that handshake still completes.
        @(posedge clk);
        #1;
        din = 11'd999;
        rready_a = 1'b1;
        push_a(999, 3, 2, 1, 0, 0);
        wait_read(0, "en_drop_handshake");
        en = 1'b0;
        @(posedge clk);
        #1;
        rready_a = 1'b0;
        @(posedge clk);
        #1;
        din = 11'd0;
        rready_a = 1'b1;
        r0 = reads_a;
        repeat (4) @(posedge clk);
        #1;
        cmp("en_low_no_read", reads_a - r0, 0);
        push_a(0, 4, 3, 1, 0, 1);
        en = 1'b1;
        wait_read(0, "en_restore_handshake");
        @(posedge clk);
        #1;
        rready_a = 1'b0;
        repeat (3) @(posedge clk);

        // Saturation on the narrow-counter instance.
        for (int i = 1; i <= 10; i++) begin
            if (i <= 7) push_b(i, i, i, 0, 0, (i == 7) ? 1 : 0);
            else        push_b(i, 7, 7, 1, 7, 1);
            send(1, i, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        cmp("b_final_count", count_b, 7);
        cmp("a_queue_drained", q_a.size(), 0);
        cmp("b_queue_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
